vend_slots: RTL

VEND_SLOTS -- requirements
Module: vend_slots

---
 rtl/vend_pkg.sv | 24 ++
 rtl/vend_slot.sv | 43 ++++
 rtl/vend_slots.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared constants for the multi-slot vending block: FSM state codes,
// deny reason codes and the default price / initial stock tables.
package vend_pkg;

    localparam int DEF_N_SLOTS = 4;
    localparam int DEF_CW      = 7;
    localparam int DEF_SW      = 4;

    // FSM state codes, kept as plain constants so older blocks can share them
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_VEND   = 2'd1;
    localparam state_t ST_REFUND = 2'd2;

    // Reason reported alongside a deny pulse
    localparam logic [1:0] DENY_NONE    = 2'b00;
    localparam logic [1:0] DENY_CREDIT  = 2'b01;
    localparam logic [1:0] DENY_SOLDOUT = 2'b10;

    // Slot3..slot0, slot0 in the LSBs
    localparam logic [DEF_N_SLOTS*DEF_CW-1:0] DEF_COST       = {7'd30, 7'd15, 7'd10, 7'd5};
    localparam logic [DEF_N_SLOTS*DEF_SW-1:0] DEF_INIT_STOCK = {4'd1, 4'd1, 4'd2, 4'd6};

endpackage

// File: rtl/vend_slot.sv
// One item slot: stock counter with saturating restock and single-unit
// decrement, plus sold-out and affordable flags for the purchase decision.
module vend_slot
    import vend_pkg::*;
#(
    parameter int            CW       = DEF_CW,
    parameter int            SW       = DEF_SW,
    parameter logic [CW-1:0] COST_VAL = '0,
    parameter logic [SW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          dec,
    input  logic          add_valid,
    input  logic [SW-1:0] add_qty,
    input  logic [CW-1:0] credit,
    output logic [SW-1:0] stock,
    output logic          sold_out,
    output logic          affordable
);

    logic [SW:0] stock_sum;

    // Restock and dispense combine into one sum; a dispense never hits an empty slot
    always_comb begin
        stock_sum = {1'b0, stock} + (add_valid ? {1'b0, add_qty} : '0) - {{SW{1'b0}}, dec};
    end

    // Stock register, clamped at the counter's maximum
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            stock <= INIT_VAL;
        end else if (stock_sum[SW]) begin
            stock <= '1;
        end else begin
            stock <= stock_sum[SW-1:0];
        end
    end

    assign sold_out   = (stock == '0);
    assign affordable = (credit >= COST_VAL);

endmodule

// File: rtl/vend_slots.sv
// Multi-slot vending controller: accumulates coin credit, arbitrates
// purchases to the lowest requested slot, denies sold-out or unaffordable
// requests, refunds on demand and accepts restocking at any time.
module vend_slots
    import vend_pkg::*;
#(
    parameter int                     N_SLOTS    = DEF_N_SLOTS,
    parameter int                     CW         = DEF_CW,
    parameter int                     SW         = DEF_SW,
    parameter logic [N_SLOTS*CW-1:0]  COST       = DEF_COST,
    parameter logic [N_SLOTS*SW-1:0]  INIT_STOCK = DEF_INIT_STOCK,
    parameter int                     SELW       = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  coin_valid,
    input  logic [CW-1:0]         coin_value,
    input  logic [N_SLOTS-1:0]    buy_req,
    input  logic                  refund_req,
    input  logic                  restock_valid,
    input  logic [SELW-1:0]       restock_slot,
    input  logic [SW-1:0]         restock_qty,
    output logic [CW-1:0]         credit,
    output logic [N_SLOTS-1:0]    vend,
    output logic                  deny,
    output logic [1:0]            deny_code,
    output logic                  change_valid,
    output logic [CW-1:0]         change_amt,
    output logic [N_SLOTS*SW-1:0] stock,
    output logic                  busy
);

    state_t               state;
    state_t               state_next;
    logic [SELW-1:0]      sel_idx;
    logic [N_SLOTS-1:0]   sel_onehot;
    logic [CW-1:0]        sel_cost;
    logic [N_SLOTS-1:0]   sold_out;
    logic [N_SLOTS-1:0]   affordable;
    logic [N_SLOTS-1:0]   dec;
    logic                 idle;
    logic                 buy_any;
    logic                 accept;
    logic                 deny_soldout;
    logic                 deny_credit;
    logic                 do_refund;
    logic [CW:0]          credit_sum;
    logic [CW-1:0]        credit_next;

    assign idle    = (state == ST_IDLE);
    assign busy    = ~idle;
    assign buy_any = |buy_req;

    // Pick the lowest-index requested slot; higher requests are simply dropped
    always_comb begin
        sel_idx    = '0;
        sel_onehot = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (buy_req[i]) begin
                sel_idx        = SELW'(i);
                sel_onehot     = '0;
                sel_onehot[i]  = 1'b1;
            end
        end
    end

    // Purchase / refund decision; sold-out outranks insufficient credit, buy outranks refund
    always_comb begin
        sel_cost     = COST[sel_idx*CW +: CW];
        accept       = idle && buy_any && !sold_out[sel_idx] && affordable[sel_idx];
        deny_soldout = idle && buy_any && sold_out[sel_idx];
        deny_credit  = idle && buy_any && !sold_out[sel_idx] && !affordable[sel_idx];
        do_refund    = idle && !buy_any && refund_req && (credit != '0);
        dec          = accept ? sel_onehot : '0;
        if (accept) begin
            state_next = ST_VEND;
        end else if (do_refund) begin
            state_next = ST_REFUND;
        end else begin
            state_next = ST_IDLE;
        end
    end

    // Next credit: a refund empties the balance, coins always land, result saturates
    always_comb begin
        credit_sum = (do_refund ? '0 : ({1'b0, credit} - (accept ? {1'b0, sel_cost} : '0)))
                   + (coin_valid ? {1'b0, coin_value} : '0);
        credit_next = credit_sum[CW] ? '1 : credit_sum[CW-1:0];
    end

    // Per-slot stock registers; an out-of-range restock slot matches no instance
    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        logic [SW-1:0] slot_stock;

        vend_slot #(
            .CW       (CW),
            .SW       (SW),
            .COST_VAL (COST[g*CW +: CW]),
            .INIT_VAL (INIT_STOCK[g*SW +: SW])
        ) u_slot (
            .clk        (clk),
            .Reset      (Reset),
            .dec        (dec[g]),
            .add_valid  (restock_valid && (restock_slot == SELW'(g))),
            .add_qty    (restock_qty),
            .credit     (credit),
            .stock      (slot_stock),
            .sold_out   (sold_out[g]),
            .affordable (affordable[g])
        );

        assign stock[g*SW +: SW] = slot_stock;
    end

    // FSM, credit and the registered one-cycle result pulses
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state        <= ST_IDLE;
            credit       <= '0;
            vend         <= '0;
            deny         <= 1'b0;
            deny_code    <= DENY_NONE;
            change_valid <= 1'b0;
            change_amt   <= '0;
        end else begin
            state        <= state_next;
            credit       <= credit_next;
            vend         <= dec;
            deny         <= deny_soldout || deny_credit;
            deny_code    <= deny_soldout ? DENY_SOLDOUT : (deny_credit ? DENY_CREDIT : DENY_NONE);
            change_valid <= do_refund;
            change_amt   <= do_refund ? credit : '0;
        end
    end

endmodule
